clause_buffer_axil_slave: RTL and testbench

CLAUSE_BUFFER_AXIL_SLAVE -- requirements
Module: clause_buffer_axil_slave

---
 rtl/clause_buffer_axil_slave.sv | 153 +++++++++++++++
 tb/tb_clause_buffer_axil_slave.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clause_buffer_axil_slave.sv
// AXI4-Lite slave holding a 128-bit clause in four RW registers; writing REG3 publishes it on a valid/ready port.
// Define CLAUSE_BUFFER_WSTRB_EN to honour WSTRB byte lanes; otherwise every mapped write updates the full word.
module clause_buffer_axil_slave #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 5
) (
    input  logic                            ACLK,
    input  logic                            ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic [4*C_S_AXI_DATA_WIDTH-1:0] clause_data,
    output logic                            clause_valid,
    input  logic                            clause_ready
);

    localparam int DW = C_S_AXI_DATA_WIDTH;
    localparam int NB = DW / 8;
    localparam int IW = C_S_AXI_ADDR_WIDTH - 2;

    localparam logic [1:0]    RESP_OKAY   = 2'b00;
    localparam logic [1:0]    RESP_SLVERR = 2'b10;
    localparam logic [IW-1:0] IDX_REG3    = IW'(3);
    localparam logic [IW-1:0] IDX_STATUS  = IW'(4);

    logic          aw_full;
    logic          w_full;
    logic [IW-1:0] aw_idx;
    logic [DW-1:0] w_data;
    logic [NB-1:0] w_strb;
    logic [DW-1:0] regs [4];
    logic [7:0]    commit_cnt;

    logic          wr_exec;
    logic          wr_mapped;
    logic [DW-1:0] wr_word;
    logic [IW-1:0] rd_idx;
    logic [DW-1:0] rd_word;
    logic [1:0]    rd_resp;
    logic          unused_bits;

    assign S_AXI_AWREADY = ~aw_full & ~ARESET;
    assign S_AXI_WREADY  = ~w_full & ~ARESET;
    assign S_AXI_ARREADY = ~S_AXI_RVALID & ~ARESET;

    assign clause_data = {regs[3], regs[2], regs[1], regs[0]};

    // REG3 is the commit trigger, so it must wait until the previous clause has been taken.
    assign wr_mapped = (aw_idx < IDX_STATUS);
    assign wr_exec   = aw_full & w_full & ~S_AXI_BVALID & ~((aw_idx == IDX_REG3) & clause_valid);
    assign rd_idx    = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];

    // NOTE: every signal written in an always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        wr_word = w_data;
`ifdef CLAUSE_BUFFER_WSTRB_EN
        for (int b = 0; b < NB; b++) begin
            if (!w_strb[b]) wr_word[8*b +: 8] = regs[aw_idx[1:0]][8*b +: 8];
        end
`endif
    end

    always_comb begin
        rd_word = '0;
        rd_resp = RESP_SLVERR;
        if (rd_idx < IDX_STATUS) begin
            rd_word = regs[rd_idx[1:0]];
            rd_resp = RESP_OKAY;
        end else if (rd_idx == IDX_STATUS) begin
            rd_word[15:8] = commit_cnt;
            rd_word[0]    = clause_valid;
            rd_resp       = RESP_OKAY;
        end
    end

    // NOTE: state is updated with non-blocking assignments so every process sees pre-edge values.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            aw_full      <= 1'b0;
            w_full       <= 1'b0;
            aw_idx       <= '0;
            w_data       <= '0;
            w_strb       <= '0;
            S_AXI_BVALID <= 1'b0;
            S_AXI_BRESP  <= RESP_OKAY;
            S_AXI_RVALID <= 1'b0;
            S_AXI_RDATA  <= '0;
            S_AXI_RRESP  <= RESP_OKAY;
            clause_valid <= 1'b0;
            commit_cnt   <= '0;
            // NOTE: the register file is reset explicitly because clause_data exposes it directly.
            for (int i = 0; i < 4; i++) regs[i] <= '0;
        end else begin
            if (S_AXI_AWVALID && S_AXI_AWREADY) begin
                aw_full <= 1'b1;
                aw_idx  <= S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
            end
            if (S_AXI_WVALID && S_AXI_WREADY) begin
                w_full <= 1'b1;
                w_data <= S_AXI_WDATA;
                w_strb <= S_AXI_WSTRB;
            end

            if (wr_exec) begin
                aw_full      <= 1'b0;
                w_full       <= 1'b0;
                S_AXI_BVALID <= 1'b1;
                S_AXI_BRESP  <= wr_mapped ? RESP_OKAY : RESP_SLVERR;
                if (wr_mapped) regs[aw_idx[1:0]] <= wr_word;
                if (aw_idx == IDX_REG3) clause_valid <= 1'b1;
            end else if (S_AXI_BVALID && S_AXI_BREADY) begin
                S_AXI_BVALID <= 1'b0;
            end

            if (clause_valid && clause_ready) begin
                clause_valid <= 1'b0;
                commit_cnt   <= commit_cnt + 8'd1;
            end

            // Read data is captured at the AR handshake, so a same-edge write is not visible.
            if (S_AXI_ARVALID && S_AXI_ARREADY) begin
                S_AXI_RVALID <= 1'b1;
                S_AXI_RDATA  <= rd_word;
                S_AXI_RRESP  <= rd_resp;
            end else if (S_AXI_RVALID && S_AXI_RREADY) begin
                S_AXI_RVALID <= 1'b0;
            end
        end
    end

`ifdef CLAUSE_BUFFER_WSTRB_EN
    assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};
`else
    assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0], w_strb};
`endif

endmodule

// File: tb/tb_clause_buffer_axil_slave.sv
// Directed self-checking bench for clause_buffer_axil_slave; inputs change 1ns after the rising edge,
// outputs are sampled on the falling edge.
module tb_clause_buffer_axil_slave;

    logic         clk = 1'b0;
    logic         areset;
    logic [4:0]   awaddr;
    logic [2:0]   awprot;
    logic         awvalid;
    logic         awready;
    logic [31:0]  wdata;
    logic [3:0]   wstrb;
    logic         wvalid;
    logic         wready;
    logic [1:0]   bresp;
    logic         bvalid;
    logic         bready;
    logic [4:0]   araddr;
    logic [2:0]   arprot;
    logic         arvalid;
    logic         arready;
    logic [31:0]  rdata;
    logic [1:0]   rresp;
    logic         rvalid;
    logic         rready;
    logic [127:0] clause_data;
    logic         clause_valid;
    logic         clause_ready;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    clause_buffer_axil_slave dut (
        .ACLK          (clk),
        .ARESET        (areset),
        .S_AXI_AWADDR  (awaddr),
        .S_AXI_AWPROT  (awprot),
        .S_AXI_AWVALID (awvalid),
        .S_AXI_AWREADY (awready),
        .S_AXI_WDATA   (wdata),
        .S_AXI_WSTRB   (wstrb),
        .S_AXI_WVALID  (wvalid),
        .S_AXI_WREADY  (wready),
        .S_AXI_BRESP   (bresp),
        .S_AXI_BVALID  (bvalid),
        .S_AXI_BREADY  (bready),
        .S_AXI_ARADDR  (araddr),
        .S_AXI_ARPROT  (arprot),
        .S_AXI_ARVALID (arvalid),
        .S_AXI_ARREADY (arready),
        .S_AXI_RDATA   (rdata),
        .S_AXI_RRESP   (rresp),
        .S_AXI_RVALID  (rvalid),
        .S_AXI_RREADY  (rready),
        .clause_data   (clause_data),
        .clause_valid  (clause_valid),
        .clause_ready  (clause_ready)
    );

    task automatic check(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic do_reset(input int cycles);
        areset = 1'b1;
        repeat (cycles) begin
            @(negedge clk);
            check("rst_awready", awready, 1'b0);
            check("rst_wready", wready, 1'b0);
            check("rst_arready", arready, 1'b0);
        end
        @(posedge clk); #1;
        areset = 1'b0;
    endtask

    // Presents AW and W together and drops each valid after its own handshake.
    task automatic issue(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] strb);
        bit aw_done;
        bit w_done;
        bit aw_hs;
        bit w_hs;
        aw_done = 1'b0;
        w_done  = 1'b0;
        awaddr  = addr;
        wdata   = data;
        wstrb   = strb;
        awvalid = 1'b1;
        wvalid  = 1'b1;
        for (int i = 0; i < 20 && !(aw_done && w_done); i++) begin
            @(negedge clk);
            aw_hs = awvalid && awready;
            w_hs  = wvalid && wready;
            @(posedge clk); #1;
            if (aw_hs) begin awvalid = 1'b0; aw_done = 1'b1; end
            if (w_hs)  begin wvalid  = 1'b0; w_done  = 1'b1; end
        end
        awvalid = 1'b0;
        wvalid  = 1'b0;
        check("aw_w_handshake", {aw_done, w_done}, 2'b11);
    endtask

    task automatic b_wait(input int budget, output bit got, output logic [1:0] resp);
        got    = 1'b0;
        resp   = 2'b11;
        bready = 1'b1;
        for (int i = 0; i < budget && !got; i++) begin
            @(negedge clk);
            if (bvalid) begin
                got  = 1'b1;
                resp = bresp;
            end
            @(posedge clk); #1;
        end
        bready = 1'b0;
    endtask

    task automatic axi_write(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             output logic [1:0] resp);
        bit got;
        issue(addr, data, strb);
        b_wait(20, got, resp);
        check("b_response_seen", got, 1'b1);
    endtask

    task automatic axi_read(input logic [4:0] addr, output logic [31:0] data, output logic [1:0] resp);
        bit hs;
        bit got;
        hs      = 1'b0;
        got     = 1'b0;
        data    = 32'hxxxx_xxxx;
        resp    = 2'b11;
        araddr  = addr;
        arvalid = 1'b1;
        rready  = 1'b1;
        for (int i = 0; i < 20 && !hs; i++) begin
            @(negedge clk);
            hs = arready;
            @(posedge clk); #1;
        end
        arvalid = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (rvalid) begin
                got  = 1'b1;
                data = rdata;
                resp = rresp;
            end
            @(posedge clk); #1;
        end
        rready = 1'b0;
        check("ar_r_handshake", {hs, got}, 2'b11);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach its summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1:0]  resp;
        logic [31:0] data;
        logic [31:0] exp_strb;
        bit          got;

        areset       = 1'b1;
        awaddr       = '0;
        awprot       = 3'b010;
        awvalid      = 1'b0;
        wdata        = '0;
        wstrb        = '0;
        wvalid       = 1'b0;
        bready       = 1'b0;
        araddr       = '0;
        arprot       = 3'b001;
        arvalid      = 1'b0;
        rready       = 1'b0;
        clause_ready = 1'b0;

        // Reset state
        do_reset(2);
        @(negedge clk);
        check("post_rst_bvalid", bvalid, 1'b0);
        check("post_rst_rvalid", rvalid, 1'b0);
        check("post_rst_clause_valid", clause_valid, 1'b0);
        check("post_rst_clause_data", clause_data, 128'h0);
        check("post_rst_awready", awready, 1'b1);
        check("post_rst_arready", arready, 1'b1);
        @(posedge clk); #1;

        // Fill REG0-REG3 and read back
        for (int i = 0; i < 4; i++) begin
            axi_write(5'(i * 4), 32'(i + 1), 4'hF, resp);
            check($sformatf("wr_reg%0d_bresp", i), resp, 2'b00);
        end
        check("fill_clause_valid", clause_valid, 1'b1);
        check("fill_clause_data", clause_data, 128'h00000004_00000003_00000002_00000001);
        for (int i = 0; i < 4; i++) begin
            axi_read(5'(i * 4), data, resp);
            check($sformatf("rd_reg%0d_data", i), data, 32'(i + 1));
            check($sformatf("rd_reg%0d_rresp", i), resp, 2'b00);
        end
        axi_read(5'h10, data, resp);
        check("status_pending", data, 32'h0000_0001);
        check("status_rresp", resp, 2'b00);

        // Consume the clause
        clause_ready = 1'b1;
        @(posedge clk); #1;
        clause_ready = 1'b0;
        @(negedge clk);
        check("consume_clause_valid", clause_valid, 1'b0);
        @(posedge clk); #1;
        axi_read(5'h10, data, resp);
        check("status_after_consume", data, 32'h0000_0100);

        // Unmapped and read-only targets
        axi_write(5'h14, 32'hDEADBEEF, 4'hF, resp);
        check("wr_unmapped_bresp", resp, 2'b10);
        axi_write(5'h10, 32'hFFFFFFFF, 4'hF, resp);
        check("wr_status_bresp", resp, 2'b10);
        axi_read(5'h1C, data, resp);
        check("rd_unmapped_data", data, 32'h0);
        check("rd_unmapped_rresp", resp, 2'b10);
        check("regs_after_slverr", clause_data, 128'h00000004_00000003_00000002_00000001);
        check("clause_valid_after_slverr", clause_valid, 1'b0);

        // Partial strobe write to REG1
        axi_write(5'h04, 32'h11111111, 4'hF, resp);
        axi_write(5'h04, 32'hAABBCCDD, 4'b0101, resp);
        check("wstrb_bresp", resp, 2'b00);
`ifdef CLAUSE_BUFFER_WSTRB_EN
        exp_strb = 32'h11BB11DD;
`else
        exp_strb = 32'hAABBCCDD;
`endif
        axi_read(5'h04, data, resp);
        check("wstrb_reg1", data, exp_strb);

        // W leads AW by two cycles
        awaddr = 5'h08;
        wdata  = 32'h0000_0055;
        wstrb  = 4'hF;
        wvalid = 1'b1;
        @(posedge clk); #1;
        wvalid = 1'b0;
        @(negedge clk);
        check("w_first_wready", wready, 1'b0);
        check("w_first_bvalid", bvalid, 1'b0);
        @(posedge clk); #1;
        awvalid = 1'b1;
        @(posedge clk); #1;
        awvalid = 1'b0;
        @(negedge clk);
        check("aw_late_bvalid_low", bvalid, 1'b0);
        check("aw_late_awready", awready, 1'b0);
        @(negedge clk);
        check("aw_late_bvalid_high", bvalid, 1'b1);
        check("aw_late_bresp", bresp, 2'b00);
        bready = 1'b1;
        @(posedge clk); #1;
        bready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("single_write_only", bvalid, 1'b0);
        @(posedge clk); #1;
        axi_read(5'h08, data, resp);
        check("w_first_reg2", data, 32'h0000_0055);

        // REG3 stalls while the previous clause is unconsumed
        do_reset(1);
        axi_write(5'h0C, 32'h0000_000A, 4'hF, resp);
        check("commit1_bresp", resp, 2'b00);
        check("commit1_clause_valid", clause_valid, 1'b1);
        issue(5'h0C, 32'h0000_000B, 4'hF);
        b_wait(8, got, resp);
        check("commit2_withheld", got, 1'b0);
        check("commit2_reg3_unchanged", clause_data[127:96], 32'h0000_000A);
        clause_ready = 1'b1;
        @(posedge clk); #1;
        clause_ready = 1'b0;
        b_wait(8, got, resp);
        check("commit2_released", got, 1'b1);
        check("commit2_bresp", resp, 2'b00);
        check("commit2_reg3", clause_data[127:96], 32'h0000_000B);
        check("commit2_clause_valid", clause_valid, 1'b1);
        axi_read(5'h10, data, resp);
        check("status_count_one", data, 32'h0000_0101);

        // Read and write of REG0 on the same edge returns the old value
        awaddr  = 5'h00;
        wdata   = 32'h0000_0077;
        wstrb   = 4'hF;
        awvalid = 1'b1;
        wvalid  = 1'b1;
        @(posedge clk); #1;
        awvalid = 1'b0;
        wvalid  = 1'b0;
        araddr  = 5'h00;
        arvalid = 1'b1;
        @(posedge clk); #1;
        arvalid = 1'b0;
        @(negedge clk);
        check("collide_rvalid", rvalid, 1'b1);
        check("collide_rdata_old", rdata, 32'h0);
        check("collide_reg0_new", clause_data[31:0], 32'h0000_0077);
        @(negedge clk);
        check("rdata_hold_rvalid", rvalid, 1'b1);
        check("rdata_hold_value", rdata, 32'h0);
        check("rresp_hold_value", rresp, 2'b00);
        rready = 1'b1;
        @(posedge clk); #1;
        rready = 1'b0;
        @(negedge clk);
        check("collide_rvalid_cleared", rvalid, 1'b0);
        @(posedge clk); #1;
        b_wait(5, got, resp);
        check("collide_bvalid", got, 1'b1);
        axi_read(5'h00, data, resp);
        check("collide_reg0_readback", data, 32'h0000_0077);

        // Reset with a pending B response
        issue(5'h04, 32'h0000_1234, 4'hF);
        @(posedge clk); #1;
        @(negedge clk);
        check("pre_rst_bvalid", bvalid, 1'b1);
        @(posedge clk); #1;
        areset = 1'b1;
        @(negedge clk);
        check("mid_rst_awready", awready, 1'b0);
        check("mid_rst_wready", wready, 1'b0);
        check("mid_rst_arready", arready, 1'b0);
        @(posedge clk); #1;
        areset = 1'b0;
        @(negedge clk);
        check("mid_rst_bvalid", bvalid, 1'b0);
        check("mid_rst_clause_valid", clause_valid, 1'b0);
        check("mid_rst_clause_data", clause_data, 128'h0);
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            axi_read(5'(i * 4), data, resp);
            check($sformatf("mid_rst_rd%0d", i), data, 32'h0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
